// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared UART TX FIFO sizing and scheduler state encodings
package uart_tx_sched_pkg;
    localparam int UART_FIFO_DEPTH     = 16;
    localparam int UART_FIFO_COUNTER_W = 5;
    typedef enum logic {TXS_IDLE = 1'b0, TXS_XFER = 1'b1} txs_t;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: rotating priority encoder, first set req at or after ptr
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    idx,
    output logic             any
);
    logic [N_REQ-1:0] rot;
    logic [PW:0]      sum;
    assign rot = N_REQ'({req, req} >> ptr);
    assign any = |req;
    // scanning downward leaves the lowest rotated position as the winner
    always_comb begin
        idx = '0;
        sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                idx = sum >= (PW+1)'(N_REQ) ? PW'(sum - (PW+1)'(N_REQ)) : sum[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: packet-locked round-robin scheduler sharing one UART TX FIFO
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
    parameter int COUNT_W    = UART_FIFO_COUNTER_W,
    parameter int MAX_BURST  = 64
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [COUNT_W-1:0]   tf_count,
    output logic [7:0]           tdr,
    output logic                 tf_push,
    output logic [2:0]           grant_id,
    output logic                 busy
);
    localparam int PW = $clog2(N_REQ);
    txs_t          state, state_n;
    logic [PW-1:0] ptr, gnt, pick;
    logic [7:0]    bcnt;
    logic          any, space_ok, hs, done;

    uart_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req(req_valid),
        .ptr(ptr),
        .idx(pick),
        .any(any)
    );

    // a registered push is already headed for the FIFO but not yet in tf_count
    assign space_ok  = ({1'b0, tf_count} + (COUNT_W+1)'(tf_push)) < (COUNT_W+1)'(FIFO_DEPTH);
    assign hs        = state == TXS_XFER && req_valid[gnt] && space_ok;
    assign done      = hs && (req_last[gnt] || bcnt == 8'(MAX_BURST - 1));
    assign req_ready = (state == TXS_XFER && space_ok) ? N_REQ'(1) << gnt : '0;
    assign grant_id  = 3'(gnt);
    assign busy      = state == TXS_XFER;

    always_comb begin
        state_n = state;
        if (state == TXS_IDLE && any)
            state_n = TXS_XFER;
        if (done)
            state_n = TXS_IDLE;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state   <= TXS_IDLE;
            ptr     <= '0;
            gnt     <= '0;
            bcnt    <= '0;
            tdr     <= '0;
            tf_push <= 1'b0;
        end else begin
            state   <= state_n;
            tf_push <= hs;
            if (state == TXS_IDLE && any) begin
                gnt  <= pick;
                bcnt <= '0;
            end
            if (hs) begin
                tdr  <= req_data[{gnt, 3'b000} +: 8];
                bcnt <= bcnt + 8'd1;
            end
            if (done)
                ptr <= gnt == PW'(N_REQ - 1) ? '0 : gnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios with byte-queue requesters and a TX FIFO fill model
module tb_uart_tx_sched;
    localparam int N  = 4;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [N-1:0]   vld = '0, hold = '0, req_last = '0;
    logic [N-1:0]   req_valid, req_ready;
    logic [8*N-1:0] req_data = '0;
    logic [CW-1:0]  tf_count = '0;
    logic [7:0]     tdr;
    logic           tf_push, busy;
    logic [2:0]     grant_id;

    int          checks = 0, errors = 0, cyc = 0;
    int          fill = 0, fill_req = 0, fill_seq = 0, fill_seen = 0;
    bit          drain_on = 1'b1, pend_v = 1'b0;
    logic [7:0]  pend_d = '0;
    int          pend_c = 0;
    logic [N-1:0] hs_n = '0;
    logic [8:0]  mem [N][64];
    int          head [N], tail [N];
    logic [7:0]  line [$];
    int          line_cyc [$];

    assign req_valid = vld & ~hold;

    uart_tx_sched #(.N_REQ(N), .FIFO_DEPTH(16), .COUNT_W(CW), .MAX_BURST(4)) dut (
        .clk(clk), .rst_i(rst_i), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tf_count(tf_count), .tdr(tdr),
        .tf_push(tf_push), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        pend_v = tf_push;
        pend_d = tdr;
        pend_c = cyc;
        hs_n   = req_valid & req_ready;
    end

    // requester queues and FIFO fill advance on the edge the DUT samples
    always @(posedge clk) begin
        cyc++;
        if (!rst_i && pend_v) begin
            line.push_back(pend_d);
            line_cyc.push_back(pend_c);
        end
        fill = fill + ((!rst_i && pend_v) ? 1 : 0) - ((drain_on && fill > 0) ? 1 : 0);
        if (fill_seq != fill_seen) begin
            fill      = fill_req;
            fill_seen = fill_seq;
        end
        for (int i = 0; i < N; i++)
            if (!rst_i && hs_n[i]) head[i]++;
        #1;
        for (int i = 0; i < N; i++) begin
            vld[i]             = tail[i] != head[i];
            req_data[8*i +: 8] = tail[i] != head[i] ? mem[i][head[i]][7:0] : 8'h00;
            req_last[i]        = tail[i] != head[i] ? mem[i][head[i]][8] : 1'b0;
        end
        tf_count = CW'(fill);
    end

    task automatic send(input int r, input logic [7:0] d, input bit last);
        mem[r][tail[r]] = {last, d};
        tail[r]++;
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += tail[i] - head[i];
        return s;
    endfunction

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic sample_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        do begin
            sample_edge();
            n++;
        end while ((pending() != 0 || busy !== 1'b0 || tf_push !== 1'b0) && n < 300);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s drain: still active after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic do_reset();
        drive_edge();
        rst_i = 1'b1;
        drive_edge();
        drive_edge();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        sample_edge();
        checks += 5;
        if (tf_push !== 1'b0) begin errors++; $display("FAIL reset tf_push got %b want 0", tf_push); end
        if (tdr !== 8'h00) begin errors++; $display("FAIL reset tdr got %h want 00", tdr); end
        if (grant_id !== 3'd0) begin errors++; $display("FAIL reset grant_id got %0d want 0", grant_id); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset req_ready got %b want 0000", req_ready); end
        drive_edge();
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        int base, c0;
        drive_edge();
        base = line.size();
        c0   = cyc + 1;
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b1);
        wait_drain("single");
        checks++;
        if (line.size() - base != 3) begin
            errors++;
            $display("FAIL single count got %0d want 3", line.size() - base);
        end
        for (int i = 0; i < 3 && base + i < line.size(); i++) begin
            checks += 2;
            if (line[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL single byte%0d got %h want %h", i, line[base+i], exp[i]);
            end
            if (line_cyc[base+i] != c0 + 2 + i) begin
                errors++;
                $display("FAIL single push%0d cycle got %0d want %0d", i, line_cyc[base+i], c0 + 2 + i);
            end
        end
        checks++;
        if (dut.ptr !== 2'd1) begin errors++; $display("FAIL single ptr got %0d want 1", dut.ptr); end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_a [4] = '{8'h01, 8'h02, 8'h21, 8'h22};
        logic [7:0] exp_b [4] = '{8'h21, 8'h22, 8'h01, 8'h02};
        int base;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            if (r == 2) begin
                drive_edge();
                send(0, 8'h0A, 1'b1);
                wait_drain("fair_solo");
                checks++;
                if (dut.ptr !== 2'd1) begin errors++; $display("FAIL fair_solo ptr got %0d want 1", dut.ptr); end
            end
            drive_edge();
            base = line.size();
            send(0, 8'h01, 1'b0);
            send(0, 8'h02, 1'b1);
            send(2, 8'h21, 1'b0);
            send(2, 8'h22, 1'b1);
            wait_drain("fair");
            checks++;
            if (line.size() - base != 4) begin
                errors++;
                $display("FAIL fair round%0d count got %0d want 4", r, line.size() - base);
            end
            for (int i = 0; i < 4 && base + i < line.size(); i++) begin
                checks++;
                if (line[base+i] !== (r == 2 ? exp_b[i] : exp_a[i])) begin
                    errors++;
                    $display("FAIL fair round%0d byte%0d got %h want %h", r, i, line[base+i],
                             r == 2 ? exp_b[i] : exp_a[i]);
                end
            end
            if (r == 0) begin
                checks++;
                if (dut.ptr !== 2'd3) begin errors++; $display("FAIL fair ptr got %0d want 3", dut.ptr); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        int base;
        drive_edge();
        drain_on = 1'b0;
        fill_req = 16;
        fill_seq++;
        base = line.size();
        send(1, 8'h41, 1'b0);
        send(1, 8'h42, 1'b0);
        send(1, 8'h43, 1'b1);
        repeat (6) begin
            sample_edge();
            checks += 2;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full req_ready got %b want 0000", req_ready); end
            if (tf_push !== 1'b0) begin errors++; $display("FAIL bp_full tf_push got %b want 0", tf_push); end
        end
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL bp busy got %b want 1", busy); end
        if (grant_id !== 3'd1) begin errors++; $display("FAIL bp grant_id got %0d want 1", grant_id); end
        drive_edge();
        fill_req = 15;
        fill_seq++;
        repeat (6) sample_edge();
        checks += 3;
        if (line.size() - base != 1) begin errors++; $display("FAIL bp_one count got %0d want 1", line.size() - base); end
        else if (line[base] !== 8'h41) begin errors++; $display("FAIL bp_one byte got %h want 41", line[base]); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_restall req_ready got %b want 0000", req_ready); end
        if (tf_push !== 1'b0) begin errors++; $display("FAIL bp_restall tf_push got %b want 0", tf_push); end
        drive_edge();
        drain_on = 1'b1;
        wait_drain("bp");
        checks++;
        if (line.size() - base != 3) begin errors++; $display("FAIL bp count got %0d want 3", line.size() - base); end
        for (int i = 0; i < 3 && base + i < line.size(); i++) begin
            checks++;
            if (line[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL bp byte%0d got %h want %h", i, line[base+i], exp[i]);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h31, 8'h32, 8'h05, 8'h06};
        int base;
        do_reset();
        drive_edge();
        base = line.size();
        for (int i = 1; i <= 6; i++) send(0, 8'(i), i == 6);
        send(3, 8'h31, 1'b0);
        send(3, 8'h32, 1'b1);
        wait_drain("burst");
        checks++;
        if (line.size() - base != 8) begin errors++; $display("FAIL burst count got %0d want 8", line.size() - base); end
        for (int i = 0; i < 8 && base + i < line.size(); i++) begin
            checks++;
            if (line[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL burst byte%0d got %h want %h", i, line[base+i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [5] = '{8'h51, 8'h53, 8'h54, 8'h55, 8'h71};
        int base, n;
        do_reset();
        drive_edge();
        base = line.size();
        for (int i = 1; i <= 5; i++) send(1, 8'h50 + 8'(i), i == 5);
        send(3, 8'h71, 1'b1);
        n = 0;
        do begin
            sample_edge();
            n++;
        end while (line.size() - base < 1 && n < 50);
        checks += 3;
        if (n >= 50) begin errors++; $display("FAIL rst_mid wait: no push after %0d cycles", n); end
        if (tf_push !== 1'b1) begin errors++; $display("FAIL rst_mid pre tf_push got %b want 1", tf_push); end
        if (tdr !== 8'h52) begin errors++; $display("FAIL rst_mid pre tdr got %h want 52", tdr); end
        #1 rst_i = 1'b1;
        #1;
        checks += 5;
        if (tf_push !== 1'b0) begin errors++; $display("FAIL rst_mid tf_push got %b want 0", tf_push); end
        if (tdr !== 8'h00) begin errors++; $display("FAIL rst_mid tdr got %h want 00", tdr); end
        if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_mid grant_id got %0d want 0", grant_id); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %b want 0", busy); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid req_ready got %b want 0000", req_ready); end
        drive_edge();
        drive_edge();
        rst_i = 1'b0;
        wait_drain("rst_mid");
        checks++;
        if (line.size() - base != 5) begin errors++; $display("FAIL rst_mid count got %0d want 5", line.size() - base); end
        for (int i = 0; i < 5 && base + i < line.size(); i++) begin
            checks++;
            if (line[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL rst_mid byte%0d got %h want %h", i, line[base+i], exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [4] = '{8'h81, 8'h82, 8'h83, 8'h91};
        int base, n;
        drive_edge();
        base = line.size();
        send(0, 8'h81, 1'b0);
        send(0, 8'h82, 1'b0);
        send(0, 8'h83, 1'b1);
        send(2, 8'h91, 1'b1);
        n = 0;
        while (tail[0] - head[0] != 2 && n < 50) begin
            drive_edge();
            n++;
        end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL stall wait: first byte not taken after %0d cycles", n); end
        hold[0] = 1'b1;
        repeat (10) begin
            sample_edge();
            checks += 2;
            if (busy !== 1'b1) begin errors++; $display("FAIL stall busy got %b want 1", busy); end
            if (grant_id !== 3'd0) begin errors++; $display("FAIL stall grant_id got %0d want 0", grant_id); end
        end
        checks += 2;
        if (line.size() - base != 1) begin errors++; $display("FAIL stall pushes got %0d want 1", line.size() - base); end
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall req_ready got %b want 0001", req_ready); end
        drive_edge();
        hold[0] = 1'b0;
        wait_drain("stall");
        checks++;
        if (line.size() - base != 4) begin errors++; $display("FAIL stall count got %0d want 4", line.size() - base); end
        for (int i = 0; i < 4 && base + i < line.size(); i++) begin
            checks++;
            if (line[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL stall byte%0d got %h want %h", i, line[base+i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_burst();
        test_reset_mid();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
